// File: rtl/batalha_naval_jogo.sv
// Two-player one-cell battleship engine: placement phase, alternating shots,
// hit scoring and winner detection, with every output registered.
module batalha_naval_jogo #(
    parameter int unsigned POS_W      = 3,
    parameter int unsigned SHIPS      = 3,
    parameter int unsigned SCORE_W    = 2,
    parameter int unsigned EXTRA_SHOT = 0
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               valid,
    input  logic [POS_W-1:0]   coord,
    output logic [2:0]         state,
    output logic               hit,
    output logic               miss,
    output logic               dup_err,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner
);

    localparam int unsigned        Cells  = 1 << POS_W;
    localparam logic [SCORE_W-1:0] ShipsW = SCORE_W'(SHIPS);

    typedef enum logic [2:0] {
        StPlaceP1  = 3'd0,
        StPlaceP2  = 3'd1,
        StTurnP1   = 3'd2,
        StTurnP2   = 3'd3,
        StGameOver = 3'd4
    } state_e;

    state_e             r_state, w_state_d;
    logic [Cells-1:0]   r_map1, r_map2, w_map1_d, w_map2_d;
    logic [SCORE_W-1:0] r_cnt1, r_cnt2, w_cnt1_d, w_cnt2_d;
    logic [SCORE_W-1:0] r_score1, r_score2, w_score1_d, w_score2_d;
    logic               r_hit, r_miss, r_dup, w_hit_d, w_miss_d, w_dup_d;
    logic [1:0]         r_winner, w_winner_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= StPlaceP1;
            r_map1   <= '0;
            r_map2   <= '0;
            r_cnt1   <= '0;
            r_cnt2   <= '0;
            r_score1 <= '0;
            r_score2 <= '0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
            r_dup    <= 1'b0;
            r_winner <= 2'b00;
        end else begin
            r_state  <= w_state_d;
            r_map1   <= w_map1_d;
            r_map2   <= w_map2_d;
            r_cnt1   <= w_cnt1_d;
            r_cnt2   <= w_cnt2_d;
            r_score1 <= w_score1_d;
            r_score2 <= w_score2_d;
            r_hit    <= w_hit_d;
            r_miss   <= w_miss_d;
            r_dup    <= w_dup_d;
            r_winner <= w_winner_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_map1_d   = r_map1;
        w_map2_d   = r_map2;
        w_cnt1_d   = r_cnt1;
        w_cnt2_d   = r_cnt2;
        w_score1_d = r_score1;
        w_score2_d = r_score2;
        w_hit_d    = 1'b0;
        w_miss_d   = 1'b0;
        w_dup_d    = 1'b0;
        w_winner_d = r_winner;
        if (valid) begin
            unique case (r_state)
                StPlaceP1: begin
                    if (r_map1[coord]) begin
                        w_dup_d = 1'b1;
                    end else begin
                        w_map1_d[coord] = 1'b1;
                        w_cnt1_d        = r_cnt1 + 1'b1;
                        if (w_cnt1_d == ShipsW) w_state_d = StPlaceP2;
                    end
                end
                StPlaceP2: begin
                    if (r_map2[coord]) begin
                        w_dup_d = 1'b1;
                    end else begin
                        w_map2_d[coord] = 1'b1;
                        w_cnt2_d        = r_cnt2 + 1'b1;
                        if (w_cnt2_d == ShipsW) w_state_d = StTurnP1;
                    end
                end
                StTurnP1: begin
                    if (r_map2[coord]) begin
                        w_map2_d[coord] = 1'b0;
                        w_score1_d      = r_score1 + 1'b1;
                        w_hit_d         = 1'b1;
                        if (w_score1_d == ShipsW) begin
                            w_state_d  = StGameOver;
                            w_winner_d = 2'b01;
                        end else begin
                            w_state_d = (EXTRA_SHOT != 0) ? StTurnP1 : StTurnP2;
                        end
                    end else begin
                        w_miss_d  = 1'b1;
                        w_state_d = StTurnP2;
                    end
                end
                StTurnP2: begin
                    if (r_map1[coord]) begin
                        w_map1_d[coord] = 1'b0;
                        w_score2_d      = r_score2 + 1'b1;
                        w_hit_d         = 1'b1;
                        if (w_score2_d == ShipsW) begin
                            w_state_d  = StGameOver;
                            w_winner_d = 2'b10;
                        end else begin
                            w_state_d = (EXTRA_SHOT != 0) ? StTurnP2 : StTurnP1;
                        end
                    end else begin
                        w_miss_d  = 1'b1;
                        w_state_d = StTurnP1;
                    end
                end
                // Game over swallows strobes until reset.
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign hit     = r_hit;
    assign miss    = r_miss;
    assign dup_err = r_dup;
    assign score1  = r_score1;
    assign score2  = r_score2;
    assign winner  = r_winner;

endmodule

// File: tb/tb_batalha_naval_jogo.sv
// Directed bench: one instance with alternating turns, one with extra shot on hit;
// outputs are packed as {state,hit,miss,dup,score1,score2,winner}.
module tb_batalha_naval_jogo;

    logic       clk = 1'b0;
    logic       reset, valid, sel, init;
    logic [2:0] coord;

    logic [2:0] st0, st1;
    logic       h0, h1, m0, m1, d0, d1;
    logic [1:0] s10, s11, s20, s21, w0, w1;
    logic [12:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    batalha_naval_jogo #(.POS_W(3), .SHIPS(3), .SCORE_W(2), .EXTRA_SHOT(0)) u_dut0 (
        .CLOCK_50(clk), .reset(reset && (init || !sel)), .valid(valid && !sel),
        .coord(coord), .state(st0), .hit(h0), .miss(m0), .dup_err(d0),
        .score1(s10), .score2(s20), .winner(w0)
    );

    batalha_naval_jogo #(.POS_W(3), .SHIPS(3), .SCORE_W(2), .EXTRA_SHOT(1)) u_dut1 (
        .CLOCK_50(clk), .reset(reset && (init || sel)), .valid(valid && sel),
        .coord(coord), .state(st1), .hit(h1), .miss(m1), .dup_err(d1),
        .score1(s11), .score2(s21), .winner(w1)
    );

    assign obs = sel ? {st1, h1, m1, d1, s11, s21, w1} : {st0, h0, m0, d0, s10, s20, w0};

    function automatic logic [12:0] pk(input int st, input int h, input int m, input int d,
                                       input int s1, input int s2, input int w);
        return {3'(st), 1'(h), 1'(m), 1'(d), 2'(s1), 2'(s2), 2'(w)};
    endfunction

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (st,h,m,d,s1,s2,win)", tag, got, exp);
        end
    endtask

    // One-cycle strobe; outputs checked on the negedge after the sampling edge.
    task automatic strobe(input string tag, input logic [2:0] c, input logic [12:0] exp);
        @(negedge clk);
        valid = 1'b1;
        coord = c;
        @(negedge clk);
        valid = 1'b0;
        check(tag, obs, exp);
    endtask

    task automatic idle(input string tag, input int n, input logic [12:0] exp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; coord = '0; sel = 1'b0; init = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; init = 1'b0;
        @(negedge clk);
        check("reset_dut0", obs, pk(0, 0, 0, 0, 0, 0, 0));
        sel = 1'b1; #1;
        check("reset_dut1", obs, pk(0, 0, 0, 0, 0, 0, 0));
        sel = 1'b0; #1;
        idle("idle_place_p1", 100, pk(0, 0, 0, 0, 0, 0, 0));

        // Placement with one duplicate
        strobe("p1_place4",   3'd4, pk(0, 0, 0, 0, 0, 0, 0));
        strobe("p1_place0",   3'd0, pk(0, 0, 0, 0, 0, 0, 0));
        strobe("p1_dup4",     3'd4, pk(0, 0, 0, 1, 0, 0, 0));
        strobe("p1_place7",   3'd7, pk(1, 0, 0, 0, 0, 0, 0));
        idle("idle_place_p2", 100, pk(1, 0, 0, 0, 0, 0, 0));
        strobe("p2_place1",   3'd1, pk(1, 0, 0, 0, 0, 0, 0));
        strobe("p2_place2",   3'd2, pk(1, 0, 0, 0, 0, 0, 0));
        strobe("p2_place3",   3'd3, pk(2, 0, 0, 0, 0, 0, 0));
        idle("idle_turn_p1", 100, pk(2, 0, 0, 0, 0, 0, 0));

        // Shots with alternating turns
        strobe("p1_hit1",     3'd1, pk(3, 1, 0, 0, 1, 0, 0));
        strobe("p2_miss5",    3'd5, pk(2, 0, 1, 0, 1, 0, 0));
        strobe("p1_sunk1",    3'd1, pk(3, 0, 1, 0, 1, 0, 0));
        idle("idle_turn_p2", 100, pk(3, 0, 0, 0, 1, 0, 0));

        // Back-to-back strobes
        @(negedge clk);
        valid = 1'b1; coord = 3'd0;
        @(negedge clk);
        check("b2b_p2_hit0", obs, pk(2, 1, 0, 0, 1, 1, 0));
        coord = 3'd2;
        @(negedge clk);
        valid = 1'b0;
        check("b2b_p1_hit2", obs, pk(3, 1, 0, 0, 2, 1, 0));
        @(negedge clk);
        check("b2b_pulse_end", obs, pk(3, 0, 0, 0, 2, 1, 0));

        // Reset in TURN_P2 beats a simultaneous hit strobe
        reset = 1'b1; valid = 1'b1; coord = 3'd4;
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;
        check("reset_midgame", obs, pk(0, 0, 0, 0, 0, 0, 0));
        strobe("replace4",    3'd4, pk(0, 0, 0, 0, 0, 0, 0));
        strobe("replace0",    3'd0, pk(0, 0, 0, 0, 0, 0, 0));
        strobe("replace7",    3'd7, pk(1, 0, 0, 0, 0, 0, 0));

        // Extra-shot instance
        sel = 1'b1; #1;
        strobe("x_p1_place4", 3'd4, pk(0, 0, 0, 0, 0, 0, 0));
        strobe("x_p1_place0", 3'd0, pk(0, 0, 0, 0, 0, 0, 0));
        strobe("x_p1_place7", 3'd7, pk(1, 0, 0, 0, 0, 0, 0));
        strobe("x_p2_place1", 3'd1, pk(1, 0, 0, 0, 0, 0, 0));
        strobe("x_p2_place2", 3'd2, pk(1, 0, 0, 0, 0, 0, 0));
        strobe("x_p2_place3", 3'd3, pk(2, 0, 0, 0, 0, 0, 0));
        strobe("x_p1_hit2",   3'd2, pk(2, 1, 0, 0, 1, 0, 0));
        strobe("x_p1_miss6",  3'd6, pk(3, 0, 1, 0, 1, 0, 0));
        strobe("x_p2_miss5",  3'd5, pk(2, 0, 1, 0, 1, 0, 0));
        strobe("x_p1_hit1",   3'd1, pk(2, 1, 0, 0, 2, 0, 0));
        strobe("x_p1_win3",   3'd3, pk(4, 1, 0, 0, 3, 0, 1));
        strobe("x_over_v4",   3'd4, pk(4, 0, 0, 0, 3, 0, 1));
        strobe("x_over_v0",   3'd0, pk(4, 0, 0, 0, 3, 0, 1));
        idle("idle_game_over", 100, pk(4, 0, 0, 0, 3, 0, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
